regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port (W_Addr/W_Data/WE) between three writeback requesters: ALU, load unit and multiply/divide unit. It uses fixed-priority arbitration with an aging override so that no requester starves. Each request uses a valid/ready handshake. The block registers the winning write into an output stage that drives the register file's write port directly.

---
 rtl/regfile_wb_arbiter.sv | 76 +++++++
 tb/tb_regfile_wb_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between three writeback requesters
//
// Fixed-priority arbitration (index 0 = load, 1 = ALU, 2 = mul/div) with an aging
// override: a requester refused MAX_WAIT times in a row is forced to win.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   FREEZE     blocks all grants, wait counters hold
//   REQ_VALID  [2:0]  per-requester write pending
//   REQ_READY  [2:0]  per-requester accept (combinational, one-hot or zero)
//   REQ_ADDR   [14:0] requester i destination register at [5i+4:5i]
//   REQ_DATA   [95:0] requester i write data at [32i+31:32i]
//   W_Addr     [4:0]  registered write address
//   W_Data     [31:0] registered write data
//   WE                registered write enable (suppressed for $0)
//   STARVED    [2:0]  wait counter i has reached MAX_WAIT
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FREEZE,
    input  logic [2:0]  REQ_VALID,
    output logic [2:0]  REQ_READY,
    input  logic [14:0] REQ_ADDR,
    input  logic [95:0] REQ_DATA,
    output logic [4:0]  W_Addr,
    output logic [31:0] W_Data,
    output logic        WE,
    output logic [2:0]  STARVED
);
    logic [3:0]  cnt [3];
    logic [2:0]  pick;
    logic [1:0]  g_idx;
    logic [4:0]  g_addr;
    logic [31:0] g_data;
    logic        we_q;

    always_comb begin
        for (int i = 0; i < 3; i++) STARVED[i] = cnt[i] == 4'(MAX_WAIT);
        // Starved valid requesters take over the candidate set; lowest set bit wins.
        pick = |(STARVED & REQ_VALID) ? STARVED & REQ_VALID : REQ_VALID;
        REQ_READY = (RST || FREEZE) ? 3'b000 : pick & (~pick + 3'd1);
        g_idx = REQ_READY[0] ? 2'd0 : REQ_READY[1] ? 2'd1 : 2'd2;
        g_addr = REQ_ADDR[5*g_idx +: 5];
        g_data = REQ_DATA[32*g_idx +: 32];
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (RST)
                cnt[i] <= 4'd0;
            else if (!FREEZE)
                cnt[i] <= (!REQ_VALID[i] || REQ_READY[i]) ? 4'd0 : STARVED[i] ? cnt[i] : cnt[i] + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            W_Addr <= 5'd0;
            W_Data <= 32'd0;
            we_q   <= 1'b0;
        end else if (|REQ_READY) begin
            W_Addr <= g_addr;
            W_Data <= g_data;
            we_q   <= g_addr != 5'd0;
        end else begin
            we_q   <= 1'b0;
        end
    end

    // A write still held in the output stage is discarded as soon as reset is seen,
    // so it never reaches the register file.
    assign WE = we_q && !RST;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized check of the writeback arbiter against a reference model
module tb_regfile_wb_arbiter;
    localparam int M = 4;

    logic        CLK = 1'b0;
    logic        RST, FREEZE;
    logic [2:0]  REQ_VALID, REQ_READY, STARVED;
    logic [14:0] REQ_ADDR;
    logic [95:0] REQ_DATA;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        WE;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter #(.MAX_WAIT(M)) dut (
        .CLK(CLK), .RST(RST), .FREEZE(FREEZE),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .W_Addr(W_Addr), .W_Data(W_Data), .WE(WE), .STARVED(STARVED)
    );

    int checks = 0, failures = 0;
    logic [4:0]  a [3];
    logic [31:0] d [3];
    int          wait_n [3];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] rf [32];
    logic [2:0]  exp_rdy, obs_rdy, obs_starved, pv;
    logic        obs_we;
    logic [31:0] obs_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_grant(input logic r, input logic fz, input logic [2:0] v);
        if (r || fz) return 3'b000;
        for (int i = 0; i < 3; i++) if (v[i] && wait_n[i] >= M) return 3'(1 << i);
        for (int i = 0; i < 3; i++) if (v[i]) return 3'(1 << i);
        return 3'b000;
    endfunction

    task automatic step(input logic r, input logic fz, input logic [2:0] v);
        logic [2:0] exp_st;
        int idx;
        @(negedge CLK);
        RST = r;
        FREEZE = fz;
        REQ_VALID = v;
        REQ_ADDR = {a[2], a[1], a[0]};
        REQ_DATA = {d[2], d[1], d[0]};
        #1;
        exp_rdy = model_grant(r, fz, v);
        for (int i = 0; i < 3; i++) exp_st[i] = wait_n[i] >= M;
        obs_rdy = REQ_READY;
        obs_starved = STARVED;
        obs_we = WE;
        obs_data = W_Data;
        chk("ready", 32'(REQ_READY), 32'(exp_rdy));
        chk("we", 32'(WE), 32'(m_we && !r));
        chk("w_addr", 32'(W_Addr), 32'(m_addr));
        chk("w_data", W_Data, m_data);
        chk("starved", 32'(STARVED), 32'(exp_st));
        if (WE) rf[W_Addr] = W_Data;
        @(posedge CLK);
        if (r) begin
            for (int i = 0; i < 3; i++) wait_n[i] = 0;
            m_we = 1'b0;
            m_addr = 5'd0;
            m_data = 32'd0;
        end else begin
            if (exp_rdy != 3'b000) begin
                idx = exp_rdy[0] ? 0 : exp_rdy[1] ? 1 : 2;
                m_addr = a[idx];
                m_data = d[idx];
                m_we = a[idx] != 5'd0;
            end else begin
                m_we = 1'b0;
            end
            if (!fz)
                for (int i = 0; i < 3; i++)
                    wait_n[i] = (!v[i] || exp_rdy[i]) ? 0 : (wait_n[i] < M ? wait_n[i] + 1 : M);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            a[i] = 5'd0;
            d[i] = 32'd0;
            wait_n[i] = 0;
        end
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        m_we = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        RST = 1'b1;
        FREEZE = 1'b0;
        REQ_VALID = 3'b000;
        REQ_ADDR = 15'd0;
        REQ_DATA = 96'd0;
        repeat (2) @(posedge CLK);

        step(1, 0, 3'b111);
        chk("reset_ready", 32'(obs_rdy), 32'd0);

        a[1] = 5'd5;
        d[1] = 32'hDEADBEEF;
        step(0, 0, 3'b010);
        chk("alu_ready", 32'(obs_rdy), 32'b010);
        step(0, 0, 3'b000);
        chk("alu_we", 32'(obs_we), 32'd1);
        chk("alu_data", obs_data, 32'hDEADBEEF);

        a[0] = 5'd1;  d[0] = 32'h11;
        a[2] = 5'd2;  d[2] = 32'h22;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 3'b101);
            if (k < 4) chk("prio_ready", 32'(obs_rdy), 32'b001);
            if (k == 4) begin
                chk("starve_ready", 32'(obs_rdy), 32'b100);
                chk("starve_flag", 32'(obs_starved), 32'b100);
            end
        end
        step(0, 0, 3'b000);

        a[0] = 5'd0;
        d[0] = 32'h12345678;
        step(0, 0, 3'b001);
        chk("zero_ready", 32'(obs_rdy), 32'b001);
        step(0, 0, 3'b000);
        chk("zero_we", 32'(obs_we), 32'd0);

        a[0] = 5'd3;  d[0] = 32'h33;
        a[1] = 5'd4;  d[1] = 32'h44;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 3'b011);
            chk("freeze_ready", 32'(obs_rdy), 32'd0);
        end
        step(0, 0, 3'b011);
        chk("unfreeze_ready", 32'(obs_rdy), 32'b001);
        step(0, 0, 3'b010);
        step(0, 0, 3'b000);

        a[1] = 5'd9;
        d[1] = 32'h55;
        step(0, 0, 3'b010);
        step(1, 0, 3'b010);
        chk("rst_ready", 32'(obs_rdy), 32'd0);
        chk("rst_we", 32'(obs_we), 32'd0);
        step(0, 0, 3'b000);
        chk("post_rst_we", 32'(obs_we), 32'd0);
        chk("post_rst_starved", 32'(obs_starved), 32'd0);
        chk("rst_no_write", rf[9], 32'd0);

        a[0] = 5'd7;  d[0] = 32'hA;
        a[1] = 5'd7;  d[1] = 32'hB;
        step(0, 0, 3'b011);
        chk("same_first", 32'(obs_rdy), 32'b001);
        step(0, 0, 3'b010);
        chk("same_second", 32'(obs_rdy), 32'b010);
        chk("same_data_a", obs_data, 32'hA);
        step(0, 0, 3'b000);
        chk("same_data_b", obs_data, 32'hB);
        step(0, 0, 3'b000);
        chk("rf7_final", rf[7], 32'hB);
        chk("rf0_untouched", rf[0], 32'd0);

        pv = 3'b000;
        for (int n = 0; n < 400; n++) begin
            logic r, fz;
            for (int i = 0; i < 3; i++)
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1'b1;
                    a[i] = 5'($urandom);
                    d[i] = $urandom;
                end
            r = $urandom_range(0, 49) == 0;
            fz = $urandom_range(0, 7) == 0;
            step(r, fz, pv);
            pv = pv & ~exp_rdy;
        end
        step(0, 0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
